// File: rtl/gate_test_seq.sv
// gate_test_seq: drives the four input vectors of a 2-input gate under test,
// waits SETTLE_CYC cycles per vector, samples the gate output and compares it
// with the selected logic function. Reports per-vector failures and a count.
module gate_test_seq #(
   parameter int unsigned SETTLE_CYC = 4   // legal range 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] fn_sel,
   input  logic       y,
   output logic       A,
   output logic       B,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [2:0] err_count,
   output logic       cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [2:0] FN_NAND = 3'd0;
   localparam logic [2:0] FN_NOR  = 3'd1;
   localparam logic [2:0] FN_AND  = 3'd2;
   localparam logic [2:0] FN_OR   = 3'd3;
   localparam logic [2:0] FN_XOR  = 3'd4;
   localparam logic [2:0] FN_XNOR = 3'd5;

   // Last value of the settle counter before moving to SAMPLE.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
   localparam logic [2:0] ERR_MAX     = 3'd4;

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] settle_q, settle_d;
   logic [2:0] fn_q, fn_d;
   logic [3:0] fail_mask_q, fail_mask_d;
   logic [2:0] err_count_q, err_count_d;
   logic       cfg_err_q, cfg_err_d;

   // Expected gate output for the latched function; fn is always legal here.
   function automatic logic gate_ref(input logic [2:0] fn, input logic a, input logic b);
      logic r;
      case (fn)
         FN_NAND: r = ~(a & b);
         FN_NOR:  r = ~(a | b);
         FN_AND:  r = a & b;
         FN_OR:   r = a | b;
         FN_XOR:  r = a ^ b;
         FN_XNOR: r = ~(a ^ b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Next-state and result update logic.
   always_comb begin
      // NOTE: every variable gets its default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      settle_d    = settle_q;
      fn_d        = fn_q;
      fail_mask_d = fail_mask_q;
      err_count_d = err_count_q;
      cfg_err_d   = 1'b0;

      if (abort) begin
         // Abort wins over start and clears everything in any state.
         state_d     = ST_IDLE;
         cnt_d       = 2'd0;
         settle_d    = 8'd0;
         fail_mask_d = 4'd0;
         err_count_d = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (fn_sel <= FN_XNOR) begin
                     fn_d        = fn_sel;
                     cnt_d       = 2'd0;
                     settle_d    = 8'd0;
                     fail_mask_d = 4'd0;
                     err_count_d = 3'd0;
                     state_d     = ST_SETTLE;
                  end else begin
                     // Reserved function: reject without touching results.
                     cfg_err_d = 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  settle_d = 8'd0;
                  state_d  = ST_SAMPLE;
               end else begin
                  settle_d = settle_q + 8'd1;
               end
            end
            ST_SAMPLE: begin
               if (y != gate_ref(fn_q, cnt_q[1], cnt_q[0])) begin
                  fail_mask_d[cnt_q] = 1'b1;
                  if (err_count_q < ERR_MAX) begin
                     err_count_d = err_count_q + 3'd1;
                  end
               end
               if (cnt_q == 2'd3) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = ST_SETTLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and result registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         settle_q    <= 8'd0;
         fn_q        <= 3'd0;
         fail_mask_q <= 4'd0;
         err_count_q <= 3'd0;
         cfg_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         settle_q    <= settle_d;
         fn_q        <= fn_d;
         fail_mask_q <= fail_mask_d;
         err_count_q <= err_count_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign done      = (state_q == ST_DONE);
   assign pass      = done && (fail_mask_q == 4'd0);
   assign A         = busy & cnt_q[1];
   assign B         = busy & cnt_q[0];
   assign fail_mask = fail_mask_q;
   assign err_count = err_count_q;
   assign cfg_err   = cfg_err_q;

endmodule
